// File: rtl/serial_tx.sv
// Bit-serial transmitter: start bit (0), NBITS data bits LSB-first, stop bit (1).
// The line idles high. Words are accepted through a val/rdy handshake.
module serial_tx #(
    parameter int NBITS        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [NBITS-1:0] in_msg,
    output logic             tx,
    output logic             busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cyc;
    logic [CW-1:0]    cyc_nxt;
    logic [BW-1:0]    bitn;
    logic [BW-1:0]    bit_nxt;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_nxt;
    logic [NBITS-1:0] shifted;
    logic             tx_nxt;
    logic             busy_nxt;
    logic             fire;
    logic             cyc_end;

    // Ready depends only on state (and reset), never on in_val.
    assign in_rdy  = (state == IDLE) && rst_n;
    assign fire    = in_val && in_rdy;
    assign cyc_end = (cyc == CYC_LAST);
    assign shifted = shreg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cyc   <= '0;
            bitn  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cyc   <= cyc_nxt;
            bitn  <= bit_nxt;
            shreg <= shreg_nxt;
            tx    <= tx_nxt;
            busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        bit_nxt   = bitn;
        shreg_nxt = shreg;
        tx_nxt    = tx;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                // tx is forced high here so an X on in_msg can never reach the line.
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (fire) begin
                    shreg_nxt = in_msg;
                    state_nxt = START;
                    cyc_nxt   = '0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (cyc_end) begin
                    cyc_nxt   = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                    tx_nxt    = shreg[0];
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            DATA: begin
                if (cyc_end) begin
                    cyc_nxt   = '0;
                    shreg_nxt = shifted;
                    if (bitn == BIT_LAST) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        bit_nxt = bitn + 1'b1;
                        tx_nxt  = shifted[0];
                    end
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            STOP: begin
                if (cyc_end) begin
                    cyc_nxt   = '0;
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                end else begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed table-driven checks of serial_tx framing/handshake plus a
// mid-bit sampling receiver model over several CLKS_PER_BIT settings.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       val_a [3];
    logic [7:0] msg_a [3];
    logic       tx_a  [3];
    logic       busy_a[3];
    logic       rdy_a [3];
    logic       n1_val;
    logic [0:0] n1_msg;
    logic       n1_tx, n1_busy, n1_rdy;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    serial_tx #(.NBITS(8), .CLKS_PER_BIT(4)) u_main (
        .clk(clk), .rst_n(rst_n), .in_val(val_a[0]), .in_rdy(rdy_a[0]),
        .in_msg(msg_a[0]), .tx(tx_a[0]), .busy(busy_a[0]));
    serial_tx #(.NBITS(8), .CLKS_PER_BIT(3)) u_c3 (
        .clk(clk), .rst_n(rst_n), .in_val(val_a[1]), .in_rdy(rdy_a[1]),
        .in_msg(msg_a[1]), .tx(tx_a[1]), .busy(busy_a[1]));
    serial_tx #(.NBITS(8), .CLKS_PER_BIT(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_val(val_a[2]), .in_rdy(rdy_a[2]),
        .in_msg(msg_a[2]), .tx(tx_a[2]), .busy(busy_a[2]));
    serial_tx #(.NBITS(1), .CLKS_PER_BIT(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .in_val(n1_val), .in_rdy(n1_rdy),
        .in_msg(n1_msg), .tx(n1_tx), .busy(n1_busy));

    // line[i] is the bit on the wire during bit period i (0 = start, 9 = stop)
    typedef struct {
        logic [7:0] msg;
        logic [9:0] line;
        int         gap;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] obs();
        return {tx_a[0], busy_a[0], rdy_a[0]};
    endfunction

    task automatic wait_rdy(input string name);
        int k = 0;
        while (rdy_a[0] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk({name, " rdy"}, 16'(rdy_a[0]), 16'd1);
    endtask

    // Checks 40 cycles of {tx,busy,rdy} starting at the first start-bit cycle.
    task automatic frame_body(input string name, input logic [9:0] line);
        for (int c = 0; c < 40; c++) begin
            chk(name, 16'(obs()), 16'({line[c/4], 1'b1, 1'b0}));
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input vec_t v);
        repeat (v.gap) begin
            chk("pre idle", 16'(obs()), 16'(3'b101));
            @(negedge clk);
        end
        val_a[0] = 1'b1;
        msg_a[0] = v.msg;
        wait_rdy("frame");
        @(posedge clk);
        @(negedge clk);
        val_a[0] = 1'b0;
        msg_a[0] = ~v.msg;
        frame_body($sformatf("frame %h", v.msg), v.line);
        chk("frame end", 16'(obs()), 16'(3'b101));
    endtask

    // First word fires; second word is offered at cycle raise_at (0 = held
    // from the firing edge on, i.e. back-to-back) and held until accepted.
    task automatic two_frames(input string name, input logic [7:0] m1, input logic [9:0] l1,
                              input logic [7:0] m2, input logic [9:0] l2, input int raise_at);
        val_a[0] = 1'b1;
        msg_a[0] = m1;
        wait_rdy(name);
        @(posedge clk);
        @(negedge clk);
        if (raise_at == 0) begin
            msg_a[0] = m2;
        end else begin
            val_a[0] = 1'b0;
            msg_a[0] = ~m1;
        end
        for (int c = 0; c < 40; c++) begin
            if (raise_at != 0 && c == raise_at) begin
                val_a[0] = 1'b1;
                msg_a[0] = m2;
            end
            chk({name, " f1"}, 16'(obs()), 16'({l1[c/4], 1'b1, 1'b0}));
            @(negedge clk);
        end
        chk({name, " gap"}, 16'(obs()), 16'(3'b101));
        @(posedge clk);
        @(negedge clk);
        val_a[0] = 1'b0;
        msg_a[0] = ~m2;
        frame_body({name, " f2"}, l2);
        repeat (5) begin
            chk({name, " after"}, 16'(obs()), 16'(3'b101));
            @(negedge clk);
        end
    endtask

    // Receiver model: find the start edge, sample each bit mid-period.
    task automatic rand_frames(input int idx, input int cpb, input int n);
        logic [7:0] w, got;
        logic       start_ok, stop;
        int         k;
        for (int f = 0; f < n; f++) begin
            w = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            val_a[idx] = 1'b1;
            msg_a[idx] = w;
            k = 0;
            while (rdy_a[idx] !== 1'b1 && k < 100) begin
                @(negedge clk);
                k++;
            end
            @(posedge clk);
            @(negedge clk);
            val_a[idx] = 1'b0;
            msg_a[idx] = 8'($urandom);
            k = 0;
            while (tx_a[idx] !== 1'b0 && k < 5) begin
                @(negedge clk);
                k++;
            end
            repeat (cpb / 2) @(negedge clk);
            start_ok = (tx_a[idx] === 1'b0);
            for (int b = 0; b < 8; b++) begin
                repeat (cpb) @(negedge clk);
                got[b] = tx_a[idx];
            end
            repeat (cpb) @(negedge clk);
            stop = tx_a[idx];
            chk($sformatf("rx cpb%0d", cpb), {6'd0, start_ok, stop, got}, {6'd0, 1'b1, 1'b1, w});
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        logic [1:0] n1_exp[2][4];
        tbl[0] = '{msg: 8'hA5, line: 10'h34A, gap: 0};
        tbl[1] = '{msg: 8'h00, line: 10'h200, gap: 3};
        tbl[2] = '{msg: 8'hFF, line: 10'h3FE, gap: 1};
        tbl[3] = '{msg: 8'h3C, line: 10'h278, gap: 0};
        tbl[4] = '{msg: 8'h81, line: 10'h302, gap: 2};
        tbl[5] = '{msg: 8'h01, line: 10'h202, gap: 0};
        // {tx,busy} per cycle after fire for NBITS=1, CLKS_PER_BIT=1
        n1_exp[0] = '{2'b01, 2'b01, 2'b11, 2'b10};
        n1_exp[1] = '{2'b01, 2'b11, 2'b11, 2'b10};

        for (int i = 0; i < 3; i++) begin
            val_a[i] = 1'b0;
            msg_a[i] = 8'h00;
        end
        n1_val = 1'b0;
        n1_msg = 1'b0;

        // Reset, then idle with an unknown word on the bus
        repeat (3) begin
            @(negedge clk);
            chk("in reset", 16'(obs()), 16'(3'b100));
        end
        rst_n = 1'b1;
        msg_a[0] = 8'hxx;
        repeat (20) begin
            @(negedge clk);
            chk("idle", 16'(obs()), 16'(3'b101));
        end

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        two_frames("b2b", 8'h00, 10'h200, 8'hFF, 10'h3FE, 0);
        two_frames("stall", 8'h81, 10'h302, 8'h3C, 10'h278, 13);

        // Reset during DATA bit 3 of 0x5A (cycles 16..19 after fire)
        val_a[0] = 1'b1;
        msg_a[0] = 8'h5A;
        wait_rdy("midrst");
        @(posedge clk);
        @(negedge clk);
        val_a[0] = 1'b0;
        msg_a[0] = 8'hxx;
        repeat (17) @(negedge clk);
        chk("midrst bit3", 16'(obs()), 16'(3'b110));
        #2 rst_n = 1'b0;
        #1 chk("midrst async", 16'(obs()), 16'(3'b100));
        @(posedge clk);
        @(negedge clk);
        chk("midrst held", 16'(obs()), 16'(3'b100));
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst idle", 16'(obs()), 16'(3'b101));
        run_frame(tbl[4]);

        // NBITS=1, CLKS_PER_BIT=1: data 0 then data 1
        for (int d = 0; d < 2; d++) begin
            @(negedge clk);
            n1_val = 1'b1;
            n1_msg = 1'(d);
            chk("n1 rdy", 16'(n1_rdy), 16'd1);
            @(posedge clk);
            @(negedge clk);
            n1_val = 1'b0;
            n1_msg = 1'(~d);
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("n1 d%0d c%0d", d, c), 16'({n1_tx, n1_busy}), 16'(n1_exp[d][c]));
                if (c < 3) @(negedge clk);
            end
        end

        fork
            rand_frames(0, 4, 350);
            rand_frames(1, 3, 350);
            rand_frames(2, 1, 350);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
